// File: rtl/dot_vec_loader_if.sv
// AXI-Lite write-channel bundle between dot_vec_loader (master) and the vector memory (slave).
interface dot_vec_loader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/dot_vec_loader.sv
// Buffers signed (a, b) pairs, writes them over AXI-Lite to vector A/B regions, then starts the accelerator.
// Optional macro LOADER_ERR_ABORT_EN: a non-OKAY bresp aborts the job, flushes the FIFO and sets sticky err.
module dot_vec_loader #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 8,
    parameter int LEN_W       = 16,
    parameter int ADDR_STRIDE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    input  logic                go,
    input  logic [ADDR_W-1:0]   vec_a_base,
    input  logic [ADDR_W-1:0]   vec_b_base,
    input  logic [LEN_W-1:0]    vec_len,
    output logic                busy,
    output logic                start,
    input  logic                done,
    dot_vec_loader_if.master    axi,
    output logic                err
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(ADDR_STRIDE);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DATA = 3'd1,
        S_WR_A      = 3'd2,
        S_RESP_A    = 3'd3,
        S_WR_B      = 3'd4,
        S_RESP_B    = 3'd5,
        S_START     = 3'd6,
        S_WAIT_DONE = 3'd7
    } state_t;

    state_t state_r, state_n;

    logic [DATA_W-1:0] fifo_a_r [DEPTH];
    logic [DATA_W-1:0] fifo_b_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  cnt_r, cnt_n;

    logic [ADDR_W-1:0] a_base_r, b_base_r, off_r;
    logic [LEN_W-1:0]  len_r, index_r;
    logic [DATA_W-1:0] b_reg_r;

    logic [ADDR_W-1:0] awaddr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              awvalid_r, wvalid_r, bready_r;
    logic              in_ready_r, busy_r, start_r;

    logic push_s, pop_s, flush_s, resp_s, resp_bad_s, abort_s;
    logic wr_done_s, last_s, accept_s, enter_a_s, enter_b_s;

    assign push_s    = in_valid && in_ready_r;
    assign pop_s     = (state_r == S_WAIT_DATA) && (cnt_r != '0);
    assign resp_s    = ((state_r == S_RESP_A) || (state_r == S_RESP_B)) && axi.bvalid;
    assign abort_s   = resp_s && resp_bad_s;
    assign flush_s   = abort_s;
    // A channel is finished once its valid is low or is being accepted this cycle.
    assign wr_done_s = !(awvalid_r && !axi.awready) && !(wvalid_r && !axi.wready);
    assign last_s    = (index_r + LEN_W'(1)) == len_r;
    assign accept_s  = (state_r == S_IDLE) && go && (vec_len != '0);
    assign enter_a_s = (state_n == S_WR_A) && (state_r != S_WR_A);
    assign enter_b_s = (state_n == S_WR_B) && (state_r != S_WR_B);

`ifdef LOADER_ERR_ABORT_EN
    logic err_r;

    assign resp_bad_s = (axi.bresp != 2'b00);
    assign err        = err_r;

    // Sticky error: set by a failed response, cleared when the next job is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (abort_s) begin
            err_r <= 1'b1;
        end else if (accept_s) begin
            err_r <= 1'b0;
        end
    end
`else
    logic unused_bresp_s;

    assign resp_bad_s     = 1'b0;
    assign err            = 1'b0;
    assign unused_bresp_s = ^axi.bresp;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_n = S_WAIT_DATA;
                else          state_n = S_IDLE;
            end
            S_WAIT_DATA: begin
                if (pop_s) state_n = S_WR_A;
                else       state_n = S_WAIT_DATA;
            end
            S_WR_A: begin
                if (wr_done_s) state_n = S_RESP_A;
                else           state_n = S_WR_A;
            end
            S_RESP_A: begin
                if (abort_s)     state_n = S_IDLE;
                else if (resp_s) state_n = S_WR_B;
                else             state_n = S_RESP_A;
            end
            S_WR_B: begin
                if (wr_done_s) state_n = S_RESP_B;
                else           state_n = S_WR_B;
            end
            S_RESP_B: begin
                if (abort_s)               state_n = S_IDLE;
                else if (resp_s && last_s) state_n = S_START;
                else if (resp_s)           state_n = S_WAIT_DATA;
                else                       state_n = S_RESP_B;
            end
            S_START: begin
                state_n = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done) state_n = S_IDLE;
                else      state_n = S_WAIT_DONE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // FIFO occupancy for the coming cycle; in_ready is registered from it so it equals !full.
    always_comb begin
        cnt_n = cnt_r;
        if (flush_s) begin
            cnt_n = '0;
        end else if (push_s && !pop_s) begin
            cnt_n = cnt_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            cnt_n = cnt_r - CNT_W'(1);
        end else begin
            cnt_n = cnt_r;
        end
    end

    // FIFO pair storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_a_r[wr_ptr_r] <= in_a;
            fifo_b_r[wr_ptr_r] <= in_b;
        end
    end

    // FIFO pointers, count and ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
        end else begin
            if (flush_s) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            cnt_r      <= cnt_n;
            in_ready_r <= (cnt_n != DEPTH_C);
        end
    end

    // Job configuration, element index and address offset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_base_r <= '0;
            b_base_r <= '0;
            len_r    <= '0;
            index_r  <= '0;
            off_r    <= '0;
            b_reg_r  <= '0;
        end else begin
            if (accept_s) begin
                a_base_r <= vec_a_base;
                b_base_r <= vec_b_base;
                len_r    <= vec_len;
                index_r  <= '0;
                off_r    <= '0;
            end else if (resp_s && !abort_s && (state_r == S_RESP_B)) begin
                index_r <= index_r + LEN_W'(1);
                off_r   <= off_r + STRIDE_C;
            end
            if (pop_s) b_reg_r <= fifo_b_r[rd_ptr_r];
        end
    end

    // AXI master registers: address/data load on entry to a write state and then hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awaddr_r  <= '0;
            wdata_r   <= '0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
        end else begin
            if (enter_a_s) begin
                awaddr_r <= a_base_r + off_r;
                wdata_r  <= fifo_a_r[rd_ptr_r];
            end else if (enter_b_s) begin
                awaddr_r <= b_base_r + off_r;
                wdata_r  <= b_reg_r;
            end
            if (enter_a_s || enter_b_s) begin
                awvalid_r <= 1'b1;
                wvalid_r  <= 1'b1;
            end else begin
                if (axi.awready) awvalid_r <= 1'b0;
                if (axi.wready)  wvalid_r  <= 1'b0;
            end
            bready_r <= (state_n == S_RESP_A) || (state_n == S_RESP_B);
        end
    end

    // Job status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r  <= 1'b0;
            start_r <= 1'b0;
        end else begin
            busy_r  <= (state_n != S_IDLE);
            start_r <= (state_n == S_START);
        end
    end

    assign in_ready    = in_ready_r;
    assign busy        = busy_r;
    assign start       = start_r;
    assign axi.awaddr  = awaddr_r;
    assign axi.awvalid = awvalid_r;
    assign axi.wdata   = wdata_r;
    assign axi.wvalid  = wvalid_r;
    assign axi.wstrb   = {(DATA_W/8){wvalid_r}};
    assign axi.bready  = bready_r;

endmodule

// File: tb/tb_dot_vec_loader.sv
// Self-checking bench for dot_vec_loader: random pairs and slave delays, checked against a queue model of
// the expected write stream (A_i/B_i at base + 4*i, in order A0,B0,A1,B1,...).
module tb_dot_vec_loader;

    logic        clk, rst;
    logic        in_valid, go, done;
    logic [31:0] in_a, in_b, vec_a_base, vec_b_base;
    logic [15:0] vec_len;
    logic        in_ready, busy, start, err;

    dot_vec_loader_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    dot_vec_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(8), .LEN_W(16), .ADDR_STRIDE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .go(go), .vec_a_base(vec_a_base), .vec_b_base(vec_b_base), .vec_len(vec_len),
        .busy(busy), .start(start), .done(done), .axi(axi), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Model state: pairs accepted by the DUT ({a,b}), current job, write/start counters.
    logic [63:0] model_q[$];
    logic [31:0] job_a, job_b;
    int          wr_k, starts;
    int          err_k     = -1;
    int          rand_mode = 1;
    int          aw_fix    = 0;
    int          w_fix     = 0;

    initial begin
        starts = 0;
        forever begin
            @(negedge clk);
            if (start === 1'b1) starts++;
        end
    end

    // AXI-Lite slave with configurable ready delays; compares each completed write with the model.
    logic        aw_pend, w_pend, aw_done, w_done, b_fire;
    int          aw_wait, w_wait, idx;
    logic [31:0] aw_first, w_first, cap_addr, cap_data, exp_addr;
    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        aw_pend = 1'b0; w_pend = 1'b0; aw_done = 1'b0; w_done = 1'b0; b_fire = 1'b0;
        aw_wait = 0; w_wait = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
                aw_pend = 1'b0; w_pend = 1'b0; aw_done = 1'b0; w_done = 1'b0; b_fire = 1'b0;
            end else begin
                if (b_fire) begin
                    axi.bvalid = 1'b0; axi.bresp = 2'b00; b_fire = 1'b0;
                end
                if (axi.awready) begin
                    axi.awready = 1'b0; aw_done = 1'b1;
                end else if (axi.awvalid && !aw_done) begin
                    if (!aw_pend) begin
                        aw_pend = 1'b1; aw_first = axi.awaddr;
                        aw_wait = (rand_mode != 0) ? int'($urandom_range(0, 3)) : aw_fix;
                    end else begin
                        check("aw_stable", 64'(axi.awaddr), 64'(aw_first));
                    end
                    if (aw_wait == 0) begin
                        axi.awready = 1'b1; cap_addr = axi.awaddr; aw_pend = 1'b0;
                    end else begin
                        aw_wait--;
                    end
                end
                if (axi.wready) begin
                    axi.wready = 1'b0; w_done = 1'b1;
                end else if (axi.wvalid && !w_done) begin
                    if (!w_pend) begin
                        w_pend = 1'b1; w_first = axi.wdata;
                        w_wait = (rand_mode != 0) ? int'($urandom_range(0, 3)) : w_fix;
                    end else begin
                        check("w_stable", 64'(axi.wdata), 64'(w_first));
                    end
                    if (w_wait == 0) begin
                        axi.wready = 1'b1; cap_data = axi.wdata; w_pend = 1'b0;
                        check("wstrb", 64'(axi.wstrb), 64'(4'hF));
                    end else begin
                        w_wait--;
                    end
                end
                if (aw_done && w_done && !axi.bvalid) begin
                    idx      = wr_k / 2;
                    exp_addr = (((wr_k % 2) == 0) ? job_a : job_b) + 32'(idx * 4);
                    check("wr_addr", 64'(cap_addr), 64'(exp_addr));
                    if (idx < model_q.size())
                        check("wr_data", 64'(cap_data),
                              ((wr_k % 2) == 0) ? 64'(model_q[idx][63:32]) : 64'(model_q[idx][31:0]));
                    else
                        check("wr_extra", 64'(idx), 64'(model_q.size()));
                    axi.bresp  = (wr_k == err_k) ? 2'b10 : 2'b00;
                    axi.bvalid = 1'b1;
                    aw_done = 1'b0; w_done = 1'b0;
                    wr_k++;
                end
                if (axi.bvalid && axi.bready) b_fire = 1'b1;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the pair was accepted.
    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        in_a = a; in_b = b; in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("push_timeout", 64'(in_ready), 64'd1);
        end else begin
            @(negedge clk);
            model_q.push_back({a, b});
        end
        in_valid = 1'b0;
    endtask

    task automatic issue_go(input int len, input logic [31:0] ab, input logic [31:0] bb);
        job_a = ab; job_b = bb; wr_k = 0; starts = 0;
        vec_len = 16'(len); vec_a_base = ab; vec_b_base = bb; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("busy_after_go", 64'(busy), (len != 0) ? 64'd1 : 64'd0);
    endtask

    task automatic finish_job(input int len);
        int t = 0;
        while (starts == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        check("start_once", 64'(starts), 64'd1);
        check("write_count", 64'(wr_k), 64'(2 * len));
        check("busy_wait_done", 64'(busy), 64'd1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("busy_after_done", 64'(busy), 64'd0);
        for (int j = 0; j < len; j++)
            if (model_q.size() > 0) model_q.pop_front();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        int          len;
        logic [31:0] ab, bb;
        rst = 1'b1; in_valid = 1'b0; go = 1'b0; done = 1'b0;
        in_a = '0; in_b = '0; vec_a_base = '0; vec_b_base = '0; vec_len = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(start), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_awvalid", 64'(axi.awvalid), 64'd0);
        check("rst_wvalid", 64'(axi.wvalid), 64'd0);
        check("rst_bready", 64'(axi.bready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Single pair (11, -4).
        push_pair(32'd11, 32'hFFFF_FFFC);
        issue_go(1, 32'h100, 32'h200);
        finish_job(1);

        // Three pairs queued before go.
        push_pair(32'd5, -32'sd6);
        push_pair(32'd2, -32'sd3);
        push_pair(32'd7, -32'sd13);
        issue_go(3, 32'h100, 32'h200);
        finish_job(3);

        // Address held back 3 cycles, data accepted at once.
        rand_mode = 0; aw_fix = 3; w_fix = 0;
        push_pair(32'h1234_5678, 32'h8765_4321);
        issue_go(1, 32'h300, 32'h400);
        t = 0;
        while (!axi.awvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("w_dropped", 64'(axi.wvalid), 64'd0);
        check("aw_held", 64'(axi.awvalid), 64'd1);
        finish_job(1);
        rand_mode = 1;

        // Fill the FIFO, then the 9th pair enters the cycle after the first pop.
        for (int j = 0; j < 8; j++) push_pair($urandom(), $urandom());
        check("full_after_8", 64'(in_ready), 64'd0);
        in_a = 32'h0000_0009; in_b = 32'hFFFF_FFF7; in_valid = 1'b1;
        issue_go(9, 32'h1000, 32'h2000);
        check("full_at_go", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("ready_after_pop", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        model_q.push_back({32'h0000_0009, 32'hFFFF_FFF7});
        finish_job(9);

        // go with vec_len = 0 is ignored.
        issue_go(0, 32'h500, 32'h600);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("len0_no_aw", 64'(axi.awvalid), 64'd0);
            check("len0_busy", 64'(busy), 64'd0);
        end

        // Random jobs, including an address wrap past 2^32.
        for (int r = 0; r < 6; r++) begin
            len = int'($urandom_range(1, 8));
            for (int j = 0; j < len; j++) push_pair($urandom(), $urandom());
            ab = (r == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            bb = $urandom() & 32'hFFFF_FFFC;
            issue_go(len, ab, bb);
            finish_job(len);
        end

`ifdef LOADER_ERR_ABORT_EN
        // Error response on A1 aborts the job and flushes the FIFO.
        err_k = 2;
        for (int j = 0; j < 3; j++) push_pair($urandom(), $urandom());
        issue_go(3, 32'h700, 32'h800);
        t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("abort_err", 64'(err), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_no_start", 64'(starts), 64'd0);
        check("abort_writes", 64'(wr_k), 64'd3);
        err_k = -1;
        model_q.delete();
        issue_go(1, 32'h900, 32'hA00);
        check("err_cleared", 64'(err), 64'd0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("flushed_no_aw", 64'(axi.awvalid), 64'd0);
        end
        push_pair(32'hCAFE_0001, 32'hBEEF_0002);
        finish_job(1);
`endif

        // Asynchronous reset while the B write is outstanding.
        rand_mode = 0; aw_fix = 5; w_fix = 0;
        push_pair(32'h0000_00AA, 32'h0000_00BB);
        issue_go(1, 32'hB00, 32'hC00);
        t = 0;
        while (!(axi.awvalid && axi.awaddr == 32'hC00) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reached_wr_b", 64'(axi.awaddr), 64'h0000_0C00);
        rst = 1'b1;
        #1;
        check("arst_awvalid", 64'(axi.awvalid), 64'd0);
        check("arst_wvalid", 64'(axi.wvalid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_bready", 64'(axi.bready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        rand_mode = 1;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_err", 64'(err), 64'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("post_rst_idle", 64'(axi.awvalid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
